// File: rtl/muldiv_pkg.sv
// Shared encodings and helpers for the iterative multiply/divide unit.
package muldiv_pkg;

  // Operation encodings as presented on op_i.
  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } md_state_e;

  // Per-operation context captured when an op is accepted.
  typedef struct packed {
    logic is_div;   // divide (1) or multiply (0)
    logic neg;      // product / quotient must be negated in FIX
    logic rem_neg;  // remainder must be negated in FIX (signed div, dividend < 0)
    logic dz;       // divide with a zero divisor
  } md_ctx_t;

  // Widest value the negate helper handles; also bounds the 2*WIDTH product negate.
  localparam int unsigned MD_MAXW = 64;

  // Two's-complement negate of the low 'width' bits of val; upper bits forced to 0.
  function automatic logic [MD_MAXW-1:0] md_negate(input logic [MD_MAXW-1:0] val,
                                                   input int unsigned        width);
    logic [MD_MAXW-1:0] mask;
    mask = (width >= MD_MAXW) ? '1 : ((MD_MAXW'(1) << width) - MD_MAXW'(1));
    return (~val + MD_MAXW'(1)) & mask;
  endfunction

  // True for the signed variants (MULT, DIV).
  function automatic logic md_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  // True for the divide variants (DIV, DIVU).
  function automatic logic md_is_div(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/muldiv_addsub.sv
// (WIDTH+1)-bit adder/subtractor shared by the multiply add step and the
// divide trial subtract. For subtraction, carry_o=1 means a_i >= b_i (no borrow).
module muldiv_addsub
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH:0] a_i,
  input  logic [WIDTH:0] b_i,
  input  logic           sub_i,
  output logic [WIDTH:0] sum_o,
  output logic           carry_o
);

  logic [WIDTH:0] b_eff;

  // a + b, or a + ~b + 1 when subtracting; carry out of the top bit exposed.
  always_comb begin
    b_eff            = sub_i ? ~b_i : b_i;
    {carry_o, sum_o} = {1'b0, a_i} + {1'b0, b_eff} + {{(WIDTH + 1){1'b0}}, sub_i};
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide unit running beside the EX-stage ALU. One shift-add
// (multiply) or restoring-divide step per cycle on a shared add/sub, then a
// sign-fix cycle that writes HI/LO. Operates on magnitudes; signs are applied in FIX.
// WIDTH is limited to 32 so the 2*WIDTH product negate fits the package helper.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] rs_data_i,
  input  logic [WIDTH-1:0] rt_data_i,
  input  logic             hilo_rd_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             div_zero_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int unsigned CNTW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // WIDTH-bit negate built on the package helper.
  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    return WIDTH'(md_negate(MD_MAXW'(v), WIDTH));
  endfunction

  // Architectural / control state.
  md_state_e        state_q;
  logic [CNTW-1:0]  cnt_q;
  md_ctx_t          ctx_q;
  logic [WIDTH-1:0] rs_q;     // raw dividend, returned in HI on divide-by-zero
  logic [WIDTH-1:0] opb_q;    // |multiplicand| or |divisor|
  logic [WIDTH-1:0] acc_q;    // product high half / partial remainder
  logic [WIDTH-1:0] q_q;      // multiplier shifting out, product low half / quotient
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             done_q;
  logic             div_zero_q;

  // Decode of the incoming op and operand magnitudes.
  logic             in_signed;
  logic             in_div;
  logic [WIDTH-1:0] rs_abs;
  logic [WIDTH-1:0] rt_abs;
  md_ctx_t          in_ctx;

  // Operand decode at accept: magnitudes for signed ops plus result sign bits.
  always_comb begin
    in_signed      = md_is_signed(op_i);
    in_div         = md_is_div(op_i);
    rs_abs         = (in_signed && rs_data_i[WIDTH-1]) ? neg_w(rs_data_i) : rs_data_i;
    rt_abs         = (in_signed && rt_data_i[WIDTH-1]) ? neg_w(rt_data_i) : rt_data_i;
    in_ctx.is_div  = in_div;
    in_ctx.neg     = in_signed & (rs_data_i[WIDTH-1] ^ rt_data_i[WIDTH-1]);
    in_ctx.rem_neg = in_signed & rs_data_i[WIDTH-1];
    in_ctx.dz      = in_div & (rt_data_i == '0);
  end

  // Shared add/sub operands and one iteration step.
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   as_a;
  logic [WIDTH:0]   as_b;
  logic             as_sub;
  logic [WIDTH:0]   as_sum;
  logic             as_carry;
  logic [WIDTH-1:0] acc_step;
  logic [WIDTH-1:0] q_step;

  // Add/sub operand select: divide does a trial subtract of the divisor from the
  // shifted remainder; multiply adds the multiplicand when the multiplier LSB is set.
  always_comb begin
    shifted = {acc_q, q_q[WIDTH-1]};
    as_sub  = ctx_q.is_div;
    as_a    = ctx_q.is_div ? shifted : {1'b0, acc_q};
    as_b    = (ctx_q.is_div || q_q[0]) ? {1'b0, opb_q} : '0;
  end

  muldiv_addsub #(
    .WIDTH (WIDTH)
  ) u_addsub (
    .a_i     (as_a),
    .b_i     (as_b),
    .sub_i   (as_sub),
    .sum_o   (as_sum),
    .carry_o (as_carry)
  );

  // Next {acc, q} for one CALC step.
  always_comb begin
    if (ctx_q.is_div) begin
      // Restore on borrow: keep the shifted remainder, quotient bit 0.
      acc_step = as_carry ? as_sum[WIDTH-1:0] : shifted[WIDTH-1:0];
      q_step   = {q_q[WIDTH-2:0], as_carry};
    end else begin
      // Shift {carry, sum, multiplier} right by one.
      acc_step = as_sum[WIDTH:1];
      q_step   = {as_sum[0], q_q[WIDTH-1:1]};
    end
  end

  // Sign fix-up and final HI/LO values written at the end of FIX.
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  // Result selection: signed product/quotient/remainder, divide-by-zero override.
  always_comb begin
    product = ctx_q.neg ? (2 * WIDTH)'(md_negate(MD_MAXW'({acc_q, q_q}), 2 * WIDTH))
                        : {acc_q, q_q};
    quot    = ctx_q.neg ? neg_w(q_q) : q_q;
    rem     = ctx_q.rem_neg ? neg_w(acc_q) : acc_q;
    fix_hi  = product[2*WIDTH-1:WIDTH];
    fix_lo  = product[WIDTH-1:0];
    if (ctx_q.is_div) begin
      if (ctx_q.dz) begin
        fix_hi = rs_q;
        fix_lo = '1;
      end else begin
        fix_hi = rem;
        fix_lo = quot;
      end
    end
  end

  // Sequencer FSM with registered datapath, HI/LO and status outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ctx_q      <= '0;
      rs_q       <= '0;
      opb_q      <= '0;
      acc_q      <= '0;
      q_q        <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (flush_i) begin
        // Abort wins over everything, including a start in IDLE.
        state_q <= IDLE;
        cnt_q   <= '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (start_i) begin
              state_q <= CALC;
              cnt_q   <= CNTW'(WIDTH - 1);
              ctx_q   <= in_ctx;
              rs_q    <= rs_data_i;
              acc_q   <= '0;
              q_q     <= in_div ? rs_abs : rt_abs;
              opb_q   <= in_div ? rt_abs : rs_abs;
            end
          end
          CALC: begin
            acc_q <= acc_step;
            q_q   <= q_step;
            if (cnt_q == '0) begin
              state_q <= FIX;
            end else begin
              cnt_q <= cnt_q - CNTW'(1);
            end
          end
          FIX: begin
            hi_q       <= fix_hi;
            lo_q       <= fix_lo;
            div_zero_q <= ctx_q.dz;
            done_q     <= 1'b1;
            state_q    <= IDLE;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  // Status and stall: a start or HI/LO read while busy must hold EX.
  always_comb begin
    busy_o     = (state_q != IDLE);
    stall_o    = busy_o & (start_i | hilo_rd_i);
    done_o     = done_q;
    div_zero_o = div_zero_q;
    hi_o       = hi_q;
    lo_o       = lo_q;
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: latency, signed/unsigned mult/div,
// divide-by-zero, stall behaviour, flush and asynchronous reset.
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  localparam int unsigned WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [1:0]       op = 2'b00;
  logic [WIDTH-1:0] rs = '0;
  logic [WIDTH-1:0] rt = '0;
  logic             hilo_rd = 1'b0;
  logic             flush = 1'b0;
  logic             stall;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  muldiv_sequencer #(
    .WIDTH (WIDTH)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .op_i       (op),
    .rs_data_i  (rs),
    .rt_data_i  (rt),
    .hilo_rd_i  (hilo_rd),
    .flush_i    (flush),
    .stall_o    (stall),
    .busy_o     (busy),
    .done_o     (done),
    .div_zero_o (div_zero),
    .hi_o       (hi),
    .lo_o       (lo)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an op for one cycle (cycle 0); returns in cycle 1.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    op    = o;
    rs    = a;
    rt    = b;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Advance until done is seen; n is the cycle index relative to the start cycle.
  task automatic wait_done(input int from, output int n);
    n = from;
    while (done !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
  endtask

  int n;
  int seen;

  initial begin
    // Reset values, observed while reset is held.
    #1 rst = 1'b1;
    #2;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_dz", 32'(div_zero), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    tick();
    rst = 1'b0;
    tick();

    // 1. MULTU with full latency check; operands change after accept.
    issue(MD_MULTU, 32'hFFFF_FFFF, 32'h0000_0002);
    rs = 32'h1234_5678;
    rt = 32'h0000_0009;
    wait_done(1, n);
    check("t1_latency", 32'(n), 32'd34);
    check("t1_done", 32'(done), 32'd1);
    check("t1_hi", hi, 32'h0000_0001);
    check("t1_lo", lo, 32'hFFFF_FFFE);
    tick();
    check("t1_done_pulse", 32'(done), 32'd0);

    // 2. Signed multiply and divide.
    issue(MD_MULT, 32'hFFFF_FFFD, 32'd7);
    wait_done(1, n);
    check("t2_mult_lat", 32'(n), 32'd34);
    check("t2_mult_hi", hi, 32'hFFFF_FFFF);
    check("t2_mult_lo", lo, 32'hFFFF_FFEB);
    issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done(1, n);
    check("t2_div_lo", lo, 32'hFFFF_FFFD);
    check("t2_div_hi", hi, 32'hFFFF_FFFF);

    // 3. Divide by zero, sticky flag, then cleared by a normal divide.
    issue(MD_DIVU, 32'd100, 32'd0);
    wait_done(1, n);
    check("t3_dz_lo", lo, 32'hFFFF_FFFF);
    check("t3_dz_hi", hi, 32'd100);
    check("t3_dz_flag", 32'(div_zero), 32'd1);
    issue(MD_DIV, 32'hFFFF_FF9C, 32'd0);
    wait_done(1, n);
    check("t3_sdz_hi", hi, 32'hFFFF_FF9C);
    check("t3_sdz_lo", lo, 32'hFFFF_FFFF);
    tick();
    check("t3_dz_sticky", 32'(div_zero), 32'd1);
    issue(MD_DIVU, 32'd100, 32'd7);
    wait_done(1, n);
    check("t3_divu_lo", lo, 32'd14);
    check("t3_divu_hi", hi, 32'd2);
    check("t3_dz_clear", 32'(div_zero), 32'd0);

    // 4. HI/LO read while busy stalls; back-to-back start in the done cycle.
    issue(MD_MULTU, 32'd5, 32'd6);
    repeat (4) tick();
    hilo_rd = 1'b1;
    #1;
    check("t4_stall_rd", 32'(stall), 32'd1);
    wait_done(5, n);
    check("t4_latency", 32'(n), 32'd34);
    check("t4_stall_done", 32'(stall), 32'd0);
    check("t4_lo", lo, 32'd30);
    check("t4_hi", hi, 32'd0);
    op    = MD_MULTU;
    rs    = 32'd7;
    rt    = 32'd9;
    start = 1'b1;
    #1;
    check("t4_stall_start_idle", 32'(stall), 32'd0);
    tick();
    start   = 1'b0;
    hilo_rd = 1'b0;
    rs      = 32'hFFFF_FFFF;
    rt      = 32'hFFFF_FFFF;
    check("t4_accepted", 32'(busy), 32'd1);
    start = 1'b1;
    #1;
    check("t4_stall_start_busy", 32'(stall), 32'd1);
    start = 1'b0;
    wait_done(1, n);
    check("t4_b2b_latency", 32'(n), 32'd34);
    check("t4_b2b_lo", lo, 32'd63);
    check("t4_b2b_hi", hi, 32'd0);

    // 5. Flush mid-divide: no done, HI/LO untouched; flush beats start in IDLE.
    issue(MD_DIV, 32'd100, 32'd7);
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t5_busy_after_flush", 32'(busy), 32'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) seen++;
      tick();
    end
    check("t5_no_done", 32'(seen), 32'd0);
    check("t5_hi_kept", hi, 32'd0);
    check("t5_lo_kept", lo, 32'd63);
    op    = MD_MULTU;
    rs    = 32'd2;
    rt    = 32'd3;
    start = 1'b1;
    flush = 1'b1;
    tick();
    start = 1'b0;
    flush = 1'b0;
    check("t5_flush_wins", 32'(busy), 32'd0);

    // 6. Asynchronous reset mid-CALC, then signed MIN / -1.
    issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (10) tick();
    #2 rst = 1'b1;
    #1;
    check("t6_async_busy", 32'(busy), 32'd0);
    check("t6_async_lo", lo, 32'd0);
    check("t6_async_hi", hi, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(1, n);
    check("t6_min_lat", 32'(n), 32'd34);
    check("t6_min_lo", lo, 32'h8000_0000);
    check("t6_min_hi", hi, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
